// File: rtl/soundgen_pkg.sv
// Shared types and constants for the sound generator's tone sequencer.
//
// A note-table entry is packed as {half_period, duration, volume}. The offset
// helpers give field positions for any widths. The *_LSB constants give the
// positions for the default widths (N=8, DUR_W=8).
package soundgen_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPlay,
        StDone
    } state_e;

    localparam int unsigned VOL_LSB   = 0;
    localparam int unsigned DEF_N     = 8;
    localparam int unsigned DEF_DUR_W = 8;
    localparam int unsigned DUR_LSB   = VOL_LSB + DEF_N;
    localparam int unsigned HP_LSB    = DUR_LSB + DEF_DUR_W;

    // Decay prescaler width: volume drops once every 2**DECAY_SH sample ticks.
    localparam int unsigned DECAY_SH = 4;

    function automatic int unsigned dur_lsb(input int unsigned n);
        return VOL_LSB + n;
    endfunction

    function automatic int unsigned hp_lsb(input int unsigned n, input int unsigned dur_w);
        return VOL_LSB + n + dur_w;
    endfunction

endpackage

// File: rtl/tone_osc.sv
// Square-wave phase generator: a half-period counter plus phase flip-flop.
//
// Ports:
//   clk          clock
//   reset        synchronous active-high reset
//   clr          restart the waveform: counter to 0, phase high
//   half_period  half-period in clk cycles (1 toggles phase every clk)
//   phase        current square-wave phase
module tone_osc #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [DIV_W-1:0] half_period,
    output logic             phase
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == half_period - DIV_W'(1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Plays a programmable note table into the PWM DAC duty input (t_on).
//
// Each entry {half_period, duration, volume} becomes a square wave of
// amplitude volume; duration counts sample ticks, duration=0 ends the
// sequence, and half_period=0 is a rest.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start, stop  one-cycle playback start / abort pulses
//   loop_en      restart at entry 0 instead of finishing
//   sample_tick  strobe once per DAC PWM period; t_on only updates here
//   wr_en, wr_addr, wr_data   note-table write port (any state)
//   t_on         duty value to the DAC
//   busy         high in LOAD or PLAY
//   done         one-cycle pulse at the natural end of a sequence
//   note_idx     index of the entry currently playing
//
// Build option: define SOUNDGEN_DECAY_EN to make the volume decay by one
// step every 16 sample ticks within each note.
module tone_sequencer
    import soundgen_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned DUR_W = 8,
    parameter int unsigned NOTES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic                       sample_tick,
    input  logic                       wr_en,
    input  logic [$clog2(NOTES)-1:0]   wr_addr,
    input  logic [DIV_W+DUR_W+N-1:0]   wr_data,
    output logic [N-1:0]               t_on,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NOTES)-1:0]   note_idx
);

    localparam int unsigned AW     = $clog2(NOTES);
    localparam int unsigned EW     = DIV_W + DUR_W + N;
    localparam int unsigned DurLsb = dur_lsb(N);
    localparam int unsigned HpLsb  = hp_lsb(N, DUR_W);

    logic [EW-1:0]    note_tbl [NOTES];
    state_e           state;
    logic [AW-1:0]    idx;
    logic [DIV_W-1:0] hp_q;
    logic [DUR_W-1:0] dur_cnt;
    logic [N-1:0]     vol_q;
    logic             phase;
    logic             osc_clr;

    logic [EW-1:0]    entry;
    logic [DIV_W-1:0] ent_hp;
    logic [DUR_W-1:0] ent_dur;
    logic [N-1:0]     ent_vol;

`ifdef SOUNDGEN_DECAY_EN
    logic [DECAY_SH-1:0] presc;
`endif

    // Reads the registered table, so a write landing in the same cycle as a
    // LOAD is only seen by the following LOAD of that entry.
    assign entry   = note_tbl[idx];
    assign ent_hp  = entry[HpLsb +: DIV_W];
    assign ent_dur = entry[DurLsb +: DUR_W];
    assign ent_vol = entry[VOL_LSB +: N];

    assign osc_clr  = (state == StLoad);
    assign busy     = (state == StLoad) || (state == StPlay);
    assign note_idx = idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NOTES; i++) note_tbl[i] <= '0;
        end else if (wr_en) begin
            note_tbl[wr_addr] <= wr_data;
        end
    end

    tone_osc #(
        .DIV_W(DIV_W)
    ) u_osc (
        .clk        (clk),
        .reset      (reset),
        .clr        (osc_clr),
        .half_period(hp_q),
        .phase      (phase)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= StIdle;
            idx     <= '0;
            t_on    <= '0;
            done    <= 1'b0;
            hp_q    <= '0;
            dur_cnt <= '0;
            vol_q   <= '0;
`ifdef SOUNDGEN_DECAY_EN
            presc   <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    // stop wins over a simultaneous start
                    if (start && !stop) begin
                        state <= StLoad;
                        idx   <= '0;
                    end
                end
                StLoad: begin
                    if (stop) begin
                        state <= StIdle;
                        t_on  <= '0;
                    end else begin
                        hp_q    <= ent_hp;
                        vol_q   <= ent_vol;
                        dur_cnt <= ent_dur;
`ifdef SOUNDGEN_DECAY_EN
                        presc   <= '0;
`endif
                        if (ent_dur == '0) begin
                            // An end marker at entry 0 finishes even when
                            // looping, otherwise LOAD would spin forever.
                            if (loop_en && idx != '0) begin
                                idx <= '0;
                            end else begin
                                state <= StDone;
                                done  <= 1'b1;
                            end
                        end else begin
                            state <= StPlay;
                        end
                    end
                end
                StPlay: begin
                    if (stop) begin
                        state <= StIdle;
                        t_on  <= '0;
                    end else if (sample_tick) begin
                        t_on    <= (phase && hp_q != '0) ? vol_q : '0;
                        dur_cnt <= dur_cnt - DUR_W'(1);
`ifdef SOUNDGEN_DECAY_EN
                        presc <= presc + DECAY_SH'(1);
                        if (presc == '1 && vol_q != '0) vol_q <= vol_q - N'(1);
`endif
                        if (dur_cnt == DUR_W'(1)) begin
                            if (idx == AW'(NOTES - 1)) begin
                                if (loop_en) begin
                                    idx   <= '0;
                                    state <= StLoad;
                                end else begin
                                    state <= StDone;
                                    done  <= 1'b1;
                                end
                            end else begin
                                idx   <= idx + AW'(1);
                                state <= StLoad;
                            end
                        end
                    end
                end
                StDone: begin
                    t_on  <= '0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;
    import soundgen_pkg::*;

    localparam int N     = 8;
    localparam int DIV_W = 16;
    localparam int DUR_W = 8;
    localparam int NOTES = 8;
    localparam int AW    = 3;
    localparam int EW    = DIV_W + DUR_W + N;
    localparam int HMAX  = 2000;

    logic          clk = 1'b0;
    logic          reset, start, stop, loop_en, sample_tick, wr_en;
    logic [AW-1:0] wr_addr;
    logic [EW-1:0] wr_data;
    logic [N-1:0]  t_on;
    logic          busy, done;
    logic [AW-1:0] note_idx;

    always #5 clk = ~clk;

    tone_sequencer #(
        .N(N), .DIV_W(DIV_W), .DUR_W(DUR_W), .NOTES(NOTES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
        .sample_tick(sample_tick), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .t_on(t_on), .busy(busy), .done(done), .note_idx(note_idx)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] tbl [NOTES];
    int exp_ton  [HMAX];
    bit exp_busy [HMAX];
    bit exp_done [HMAX];
    int exp_idx  [HMAX];

    function automatic logic [EW-1:0] pack(input int hp, input int dur, input int vol);
        logic [EW-1:0] d;
        d = '0;
        d[HP_LSB +: DIV_W]  = hp[DIV_W-1:0];
        d[DUR_LSB +: DUR_W] = dur[DUR_W-1:0];
        d[VOL_LSB +: N]     = vol[N-1:0];
        return d;
    endfunction

    function automatic bit tick_at(input int c, input int p, input int off);
        return ((c + off) % p) == 0;
    endfunction

    // Timeline model. Cycle 0 carries the start pulse, cycle 1 is the first
    // LOAD; a note's play window begins the cycle after its LOAD, its waveform
    // is high during even-numbered half-periods counted from that cycle, each
    // tick inside the window produces a t_on value visible one cycle later,
    // and the next LOAD follows the note's last tick.
    task automatic model(input bit le, input int p, input int off, input int h,
                         input int stop_c, input int w_c, input int w_a,
                         input logic [EW-1:0] w_d);
        int upd_c[$];
        int upd_v[$];
        int t, idx, done_c, c, s, hpv, dur, vol, ve, v, cur, j;
        bit cut;
        logic [EW-1:0] e;
        for (int i = 0; i < HMAX; i++) exp_idx[i] = -1;
        t = 1; idx = 0; done_c = -1;
        while (t < h) begin
            e   = (w_c >= 0 && t > w_c && idx == w_a) ? w_d : tbl[idx];
            hpv = int'(e[HP_LSB +: DIV_W]);
            dur = int'(e[DUR_LSB +: DUR_W]);
            vol = int'(e[VOL_LSB +: N]);
            if (dur == 0) begin
                if (le && idx != 0) begin
                    idx = 0;
                    t++;
                    continue;
                end
                done_c = t + 1;
                break;
            end
            s = t + 1;
            if (s < h) exp_idx[s] = idx;
            c = s - 1;
            cut = 1'b0;
            for (int k = 1; k <= dur; k++) begin
                c++;
                while (c < h && !tick_at(c, p, off)) c++;
                if (c >= h) begin
                    cut = 1'b1;
                    break;
                end
                ve = vol;
`ifdef SOUNDGEN_DECAY_EN
                ve = vol - (k - 1) / 16;
                if (ve < 0) ve = 0;
`endif
                if (hpv == 0 || ((c - s) / hpv) % 2 != 0) v = 0;
                else v = ve;
                upd_c.push_back(c + 1);
                upd_v.push_back(v);
            end
            if (cut) break;
            if (idx == NOTES - 1) begin
                if (!le) begin
                    done_c = c + 1;
                    break;
                end
                idx = 0;
            end else begin
                idx++;
            end
            t = c + 1;
        end
        cur = 0; j = 0;
        for (int c2 = 0; c2 < h; c2++) begin
            while (j < upd_c.size() && upd_c[j] == c2) begin
                cur = upd_v[j];
                j++;
            end
            exp_ton[c2]  = (done_c >= 0 && c2 > done_c) ? 0 : cur;
            exp_busy[c2] = (c2 >= 1) && (done_c < 0 || c2 < done_c);
            exp_done[c2] = (c2 == done_c);
            if (stop_c >= 0 && c2 > stop_c) begin
                exp_ton[c2]  = 0;
                exp_busy[c2] = 1'b0;
                exp_done[c2] = 1'b0;
                exp_idx[c2]  = -1;
            end
        end
    endtask

    task automatic write_entry(input int a, input logic [EW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        tbl[a] = d;
    endtask

    task automatic run_scenario(input string name, input bit le, input int p, input int off,
                                input int h, input int stop_c, input int w_c, input int w_a,
                                input logic [EW-1:0] w_d, input int xs);
        int bad_ton, bad_busy, bad_done, bad_idx;
        int f_ton, f_busy, f_done, f_idx;
        int a_ton, e_ton, a_idx, e_idx;
        bit a_busy, a_done;
        bad_ton = 0; bad_busy = 0; bad_done = 0; bad_idx = 0;
        f_ton = -1; f_busy = -1; f_done = -1; f_idx = -1;
        a_ton = 0; e_ton = 0; a_idx = 0; e_idx = 0; a_busy = 0; a_done = 0;
        model(le, p, off, h, stop_c, w_c, w_a, w_d);
        loop_en = le; start = 1'b1; stop = 1'b0; wr_en = 1'b0;
        sample_tick = tick_at(0, p, off);
        for (int c = 1; c < h; c++) begin
            @(posedge clk); #1;
            if (t_on !== 8'(exp_ton[c])) begin
                if (bad_ton == 0) begin f_ton = c; a_ton = int'(t_on); e_ton = exp_ton[c]; end
                bad_ton++;
            end
            if (busy !== exp_busy[c]) begin
                if (bad_busy == 0) begin f_busy = c; a_busy = busy; end
                bad_busy++;
            end
            if (done !== exp_done[c]) begin
                if (bad_done == 0) begin f_done = c; a_done = done; end
                bad_done++;
            end
            if (exp_idx[c] >= 0 && note_idx !== 3'(exp_idx[c])) begin
                if (bad_idx == 0) begin f_idx = c; a_idx = int'(note_idx); e_idx = exp_idx[c]; end
                bad_idx++;
            end
            start       = (c == xs);
            stop        = (c == stop_c);
            wr_en       = (c == w_c);
            wr_addr     = w_a[AW-1:0];
            wr_data     = w_d;
            sample_tick = tick_at(c, p, off);
        end
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0; sample_tick = 1'b0; stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (w_c >= 0 && w_c < h) tbl[w_a] = w_d;

        n_tests++;
        if (bad_ton != 0) begin
            n_fail++;
            $display("FAIL %s t_on: cycle %0d got %0d expected %0d (%0d bad cycles)",
                     name, f_ton, a_ton, e_ton, bad_ton);
        end
        n_tests++;
        if (bad_busy != 0) begin
            n_fail++;
            $display("FAIL %s busy: cycle %0d got %0d expected %0d (%0d bad cycles)",
                     name, f_busy, a_busy, !a_busy, bad_busy);
        end
        n_tests++;
        if (bad_done != 0) begin
            n_fail++;
            $display("FAIL %s done: cycle %0d got %0d expected %0d (%0d bad cycles)",
                     name, f_done, a_done, !a_done, bad_done);
        end
        n_tests++;
        if (bad_idx != 0) begin
            n_fail++;
            $display("FAIL %s note_idx: cycle %0d got %0d expected %0d (%0d bad cycles)",
                     name, f_idx, a_idx, e_idx, bad_idx);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        sample_tick = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NOTES; i++) tbl[i] = '0;
    endtask

    task automatic test_reset();
        do_reset();
        // Dirty the design mid-note, then reset again.
        write_entry(0, pack(3, 5, 77));
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            sample_tick = (c % 3 == 0);
            @(posedge clk); #1;
            start = 1'b0;
        end
        do_reset();
        n_tests++;
        if (t_on !== 8'd0) begin n_fail++; $display("FAIL reset t_on: got %0d expected 0", t_on); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %0d expected 0", busy); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %0d expected 0", done); end
        n_tests++;
        if (note_idx !== 3'd0) begin
            n_fail++; $display("FAIL reset note_idx: got %0d expected 0", note_idx);
        end
        // Table was cleared: entry 0 is an end marker even with loop_en set.
        run_scenario("reset_empty_table", 1'b1, 4, 0, 20, -1, -1, 0, '0, -1);
    endtask

    task automatic test_basic();
        write_entry(0, pack(4, 3, 200));
        write_entry(1, pack(0, 0, 0));
        run_scenario("basic", 1'b0, 10, 0, 60, -1, -1, 0, '0, -1);
    endtask

    task automatic test_rest();
        write_entry(0, pack(0, 2, 255));
        write_entry(1, pack(0, 0, 0));
        run_scenario("rest", 1'b0, 6, 1, 40, -1, -1, 0, '0, -1);
    endtask

    task automatic test_loop_stop();
        int s_cyc, seen;
        for (int i = 0; i < NOTES; i++) write_entry(i, pack($urandom_range(1, 5), 1, 10 + i));
        model(1'b1, 4, 0, 200, -1, -1, 0, '0);
        s_cyc = -1; seen = 0;
        for (int c = 0; c < 200; c++) begin
            if (exp_idx[c] == 5) begin
                seen++;
                if (seen == 2 && s_cyc < 0) s_cyc = c;
            end
        end
        run_scenario("loop_stop", 1'b1, 4, 0, 200, s_cyc, -1, 0, '0, -1);
    endtask

    task automatic test_start_stop_same();
        int hits;
        write_entry(0, pack(2, 3, 90));
        start = 1'b1; stop = 1'b1; loop_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        hits = 0;
        for (int c = 0; c < 4; c++) begin
            if (busy !== 1'b0) hits++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (hits != 0) begin
            n_fail++; $display("FAIL start_stop_same busy: got high on %0d cycles expected 0", hits);
        end
    endtask

    task automatic test_start_in_play();
        for (int i = 0; i < NOTES; i++) write_entry(i, pack($urandom_range(1, 4), 2, 30 + i));
        run_scenario("start_in_play", 1'b1, 5, 2, 150, -1, -1, 0, '0, 40);
    endtask

    task automatic test_overwrite();
        write_entry(0, pack(3, 3, 100));
        write_entry(1, pack(5, 2, 80));
        write_entry(2, pack(0, 0, 0));
        run_scenario("overwrite", 1'b1, 7, 0, 200, -1, 10, 0, pack(3, 3, 50), -1);
    endtask

    task automatic test_random();
        int dur;
        for (int r = 0; r < 6; r++) begin
            int p;
            for (int i = 0; i < NOTES; i++) begin
                dur = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
                write_entry(i, pack($urandom_range(0, 9), dur, $urandom_range(0, 255)));
            end
            p = $urandom_range(2, 11);
            run_scenario($sformatf("random%0d", r), 1'($urandom_range(0, 1)), p,
                         $urandom_range(0, p - 1), 1000, -1, -1, 0, '0, -1);
        end
    endtask

`ifdef SOUNDGEN_DECAY_EN
    task automatic test_decay();
        write_entry(0, pack(1, 64, 3));
        write_entry(1, pack(0, 0, 0));
        run_scenario("decay", 1'b0, 5, 0, 400, -1, -1, 0, '0, -1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_rest();
        test_loop_stop();
        test_start_stop_same();
        test_start_in_play();
        test_overwrite();
        test_random();
`ifdef SOUNDGEN_DECAY_EN
        test_decay();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
